// File: rtl/boot_loader_if.sv
// boot_loader_if: byte-stream input and instruction-memory write bus of the program loader
interface boot_loader_if #(parameter int ADDR_WIDTH = 8);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  modport master(output in_valid, in_data, input in_ready, imem_we, imem_addr, imem_wdata);
  modport slave(input in_valid, in_data, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/boot_loader.sv
// boot_loader: loads a checksummed big-endian word image into imem and holds the core in reset until verified
module boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic         CLK,
  input  logic         Reset,
  boot_loader_if.slave bus,
  output logic         core_reset,
  output logic         done,
  output logic         error
);
  localparam logic [2:0] RST_HOLD = 3'd0;
  localparam logic [2:0] HDR      = 3'd1;
  localparam logic [2:0] LOAD     = 3'd2;
  localparam logic [2:0] CSUM     = 3'd3;
  localparam logic [2:0] RUN      = 3'd4;
  localparam logic [2:0] ERR      = 3'd5;
  localparam logic [DATA_WIDTH:0] C_MAX_N = {{DATA_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;

  logic [2:0]            r_state;
  logic [1:0]            r_byte_cnt;
  logic [DATA_WIDTH-9:0] r_shift;
  logic [DATA_WIDTH-1:0] r_words_left;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_csum;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_fire;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_bad_n;

  assign bus.in_ready = (r_state == HDR) || (r_state == LOAD) || (r_state == CSUM);
  assign w_fire       = bus.in_valid && bus.in_ready;
  assign w_last       = w_fire && (r_byte_cnt == 2'd3);
  assign w_word       = {r_shift, bus.in_data};
  assign w_bad_n      = (w_word == '0) || ({1'b0, w_word} > C_MAX_N);
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign core_reset   = r_state != RUN;
  assign done         = r_state == RUN;
  assign error        = r_state == ERR;

  // byte assembly, header/data/checksum sequencing and the registered imem write port
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state      <= RST_HOLD;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_words_left <= '0;
      r_waddr      <= '0;
      r_csum       <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_fire) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_shift    <= w_word[DATA_WIDTH-9:0];
      end
      case (r_state)
        RST_HOLD: r_state <= HDR;
        HDR: if (w_last) begin
          r_words_left <= w_word;
          r_waddr      <= '0;
          r_csum       <= '0;
          r_state      <= w_bad_n ? ERR : LOAD;
        end
        LOAD: if (w_last) begin
          r_we         <= 1'b1;
          r_addr       <= r_waddr;
          r_wdata      <= w_word;
          r_csum       <= r_csum ^ w_word;
          r_waddr      <= r_waddr + ADDR_WIDTH'(1);
          r_words_left <= r_words_left - DATA_WIDTH'(1);
          r_state      <= (r_words_left == DATA_WIDTH'(1)) ? CSUM : LOAD;
        end
        CSUM: if (w_last) r_state <= (w_word == r_csum) ? RUN : ERR;
        default: r_state <= r_state;
      endcase
    end
  end
endmodule
